// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer around the combinational decoder.
// Drives the shared memory port, gates the active-low write strobes and counts retired instructions.
module instr_sequencer #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [1:0]       operation,
    input  logic             decRegWr,
    input  logic             decMemWr,
    input  logic             decSelPC,
    input  logic             memAck,
    output logic             memReq,
    output logic             memAddrSel,
    output logic             memWr,
    output logic             irWr,
    output logic             pcWr,
    output logic             pcSrc,
    output logic             regWr,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] instrCount,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } state_t;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t             state_r;
    state_t             nxt_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [CNT_W-1:0]   count_r;
    logic               timeout_s;
    logic               memreq_r;
    logic               memaddrsel_r;
    logic               memwr_r;
    logic               pcwr_r;
    logic               pcsrc_r;
    logic               regwr_r;
    logic               busy_r;
    logic               fault_r;

    assign timeout_s = (wait_cnt_r == WAIT_LAST);

    // Next-state selection; an ack on the last tolerated cycle wins over the timeout.
    always_comb begin
        nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (run) begin
                    nxt_s = S_FETCH;
                end else begin
                    nxt_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (memAck) begin
                    nxt_s = S_DECODE;
                end else if (timeout_s) begin
                    nxt_s = S_FAULT;
                end else begin
                    nxt_s = S_FETCH;
                end
            end
            S_DECODE: nxt_s = S_EXEC;
            S_EXEC: begin
                if (operation == 2'b01) begin
                    nxt_s = S_MEM;
                end else begin
                    nxt_s = S_WB;
                end
            end
            S_MEM: begin
                if (memAck) begin
                    nxt_s = S_WB;
                end else if (timeout_s) begin
                    nxt_s = S_FAULT;
                end else begin
                    nxt_s = S_MEM;
                end
            end
            S_WB: begin
                if (run) begin
                    nxt_s = S_FETCH;
                end else begin
                    nxt_s = S_IDLE;
                end
            end
            S_FAULT: nxt_s = S_FAULT;
            default: nxt_s = S_FAULT;
        endcase
    end

    // State, wait counter, retire counter and Moore outputs decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            wait_cnt_r   <= '0;
            count_r      <= '0;
            memreq_r     <= 1'b0;
            memaddrsel_r <= 1'b0;
            memwr_r      <= 1'b1;
            pcwr_r       <= 1'b0;
            pcsrc_r      <= 1'b0;
            regwr_r      <= 1'b1;
            busy_r       <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            state_r <= nxt_s;

            if (((nxt_s == S_FETCH) || (nxt_s == S_MEM)) && (nxt_s != state_r)) begin
                wait_cnt_r <= '0;
            end else if (((state_r == S_FETCH) || (state_r == S_MEM)) && (nxt_s == state_r)) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end

            if (state_r == S_WB) begin
                count_r <= count_r + CNT_W'(1);
            end else begin
                count_r <= count_r;
            end

            memreq_r     <= (nxt_s == S_FETCH) || (nxt_s == S_MEM);
            memaddrsel_r <= (nxt_s == S_MEM);
            pcwr_r       <= (nxt_s == S_WB);
            busy_r       <= (nxt_s != S_IDLE) && (nxt_s != S_FAULT);
            fault_r      <= (nxt_s == S_FAULT);

            // The store strobe is captured on MEM entry and held until the ack.
            if (nxt_s == S_MEM) begin
                memwr_r <= (state_r == S_MEM) ? memwr_r : decMemWr;
            end else begin
                memwr_r <= 1'b1;
            end

            if (nxt_s == S_WB) begin
                regwr_r <= (operation == 2'b11) ? 1'b1 : decRegWr;
                pcsrc_r <= (operation == 2'b10) && decSelPC;
            end else begin
                regwr_r <= 1'b1;
                pcsrc_r <= 1'b0;
            end
        end
    end

    assign irWr       = (state_r == S_FETCH) && memAck;
    assign memReq     = memreq_r;
    assign memAddrSel = memaddrsel_r;
    assign memWr      = memwr_r;
    assign pcWr       = pcwr_r;
    assign pcSrc      = pcsrc_r;
    assign regWr      = regwr_r;
    assign busy       = busy_r;
    assign fault      = fault_r;
    assign instrCount = count_r;
    assign state      = state_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: instruction table with a per-instruction scoreboard,
// plus hand-written timeout and asynchronous-reset sequences.
module tb_instr_sequencer;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic [1:0]       operation;
    logic             decRegWr;
    logic             decMemWr;
    logic             decSelPC;
    logic             memAck;
    logic             memReq;
    logic             memAddrSel;
    logic             memWr;
    logic             irWr;
    logic             pcWr;
    logic             pcSrc;
    logic             regWr;
    logic             busy;
    logic             fault;
    logic [CNT_W-1:0] instrCount;
    logic [2:0]       state;

    always #5 clk = ~clk;

    instr_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .run(run), .operation(operation),
        .decRegWr(decRegWr), .decMemWr(decMemWr), .decSelPC(decSelPC),
        .memAck(memAck), .memReq(memReq), .memAddrSel(memAddrSel),
        .memWr(memWr), .irWr(irWr), .pcWr(pcWr), .pcSrc(pcSrc),
        .regWr(regWr), .busy(busy), .fault(fault),
        .instrCount(instrCount), .state(state)
    );

    typedef struct {
        logic [1:0] op;
        logic       rw;
        logic       mw;
        logic       sel;
        int         fwait;
        int         mwait;
        int         exp_cycles;
        int         exp_memcyc;
        logic       exp_regwr;
        logic       exp_pcsrc;
        logic       exp_memwr;
    } vec_t;

    vec_t vecs [16];
    vec_t sb_q [$];
    int   checks = 0;
    int   errors = 0;
    int   model_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in FETCH; the expected record is queued when it is issued.
    task automatic run_instr(input vec_t v, input logic next_run);
        vec_t e;
        int   cyc = 0;
        int   memcyc = 0;
        int   fcnt = 0;
        int   mcnt = 0;
        logic done = 1'b0;
        operation = v.op;
        decRegWr  = v.rw;
        decMemWr  = v.mw;
        decSelPC  = v.sel;
        sb_q.push_back(v);
        for (int k = 0; k < 60 && !done; k++) begin
            cyc++;
            case (state)
                3'd1: begin
                    memAck = (fcnt == v.fwait);
                    fcnt++;
                    chk("fetch_memreq", memReq, 1);
                    chk("fetch_addrsel", memAddrSel, 0);
                    chk("fetch_pcwr", pcWr, 0);
                    #1;
                    chk("fetch_irwr", irWr, memAck);
                end
                3'd4: begin
                    memAck = (mcnt == v.mwait);
                    mcnt++;
                    memcyc++;
                    chk("mem_addrsel", memAddrSel, 1);
                    chk("mem_memwr", memWr, v.exp_memwr);
                    chk("mem_regwr", regWr, 1);
                end
                3'd5: begin
                    memAck = 1'b0;
                    e = sb_q.pop_front();
                    chk("wb_cycles", cyc, e.exp_cycles);
                    chk("wb_memcycles", memcyc, e.exp_memcyc);
                    chk("wb_regwr", regWr, e.exp_regwr);
                    chk("wb_pcwr", pcWr, 1);
                    chk("wb_pcsrc", pcSrc, e.exp_pcsrc);
                    chk("wb_memwr", memWr, 1);
                    run  = next_run;
                    done = 1'b1;
                end
                default: begin
                    memAck = 1'b1;
                    chk("mid_pcwr", pcWr, 0);
                    chk("mid_regwr", regWr, 1);
                    chk("mid_busy", busy, 1);
                    #1;
                    chk("mid_irwr", irWr, 0);
                end
            endcase
            tick;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wb_wait actual_state=%0d required=WB within 60 cycles", state);
        end
        model_count = (model_count + 1) % 16;
        chk("instr_count", instrCount, model_count);
        chk("after_wb_state", state, next_run ? 3 'd1 : 3'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{2'b00, 1'b0, 1'b1, 1'b0, 0, 0,  4,  0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{2'b01, 1'b1, 1'b0, 1'b0, 0, 3,  8,  4, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{2'b10, 1'b1, 1'b1, 1'b1, 0, 0,  4,  0, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{2'b10, 1'b1, 1'b1, 1'b0, 0, 0,  4,  0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{2'b10, 1'b0, 1'b1, 1'b1, 0, 0,  4,  0, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{2'b11, 1'b0, 1'b0, 1'b1, 2, 0,  6,  0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{2'b01, 1'b0, 1'b1, 1'b0, 1, 0,  6,  1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{2'b00, 1'b1, 1'b1, 1'b1, 14, 0, 18, 0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{2'b01, 1'b1, 1'b0, 1'b0, 0, 14, 19, 15, 1'b1, 1'b0, 1'b0};
        for (int i = 9; i < 16; i++) begin
            vecs[i] = '{2'b00, 1'(i % 2), 1'b1, 1'b1, i % 3, 0, 4 + (i % 3), 0, 1'(i % 2), 1'b0, 1'b1};
        end

        rst = 1'b0; run = 1'b0; memAck = 1'b0;
        operation = 2'b00; decRegWr = 1'b1; decMemWr = 1'b1; decSelPC = 1'b0;
        #12;
        chk("rst_state", state, 0);
        chk("rst_memreq", memReq, 0);
        chk("rst_memwr", memWr, 1);
        chk("rst_regwr", regWr, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_count", instrCount, 0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("idle_state", state, 0);
            chk("idle_memreq", memReq, 0);
            chk("idle_memwr", memWr, 1);
            chk("idle_regwr", regWr, 1);
            chk("idle_busy", busy, 0);
            chk("idle_count", instrCount, 0);
        end

        run = 1'b1;
        tick;
        chk("first_fetch", state, 1);
        for (int i = 0; i < 16; i++) begin
            run_instr(vecs[i], (i != 15));
        end
        chk("wrap_count", instrCount, 0);

        // Fetch that never gets acked must fault after exactly MEM_TIMEOUT request cycles.
        run = 1'b1;
        tick;
        memAck = 1'b0;
        n = 0;
        while (state == 3'd1 && n < 40) begin
            n++;
            tick;
        end
        chk("timeout_cycles", n, MEM_TIMEOUT);
        for (int i = 0; i < 5; i++) begin
            chk("fault_state", state, 7);
            chk("fault_flag", fault, 1);
            chk("fault_busy", busy, 0);
            chk("fault_memreq", memReq, 0);
            chk("fault_memwr", memWr, 1);
            chk("fault_regwr", regWr, 1);
            memAck = 1'b1;
            tick;
        end

        rst = 1'b0;
        #2;
        chk("fault_clear", fault, 0);
        chk("fault_clear_state", state, 0);
        rst = 1'b1;
        operation = 2'b01; decMemWr = 1'b0; decRegWr = 1'b1; run = 1'b1; memAck = 1'b1;
        tick;
        chk("ar_fetch", state, 1);
        tick;
        run = 1'b0;
        tick;
        memAck = 1'b0;
        tick;
        chk("ar_mem_state", state, 4);
        chk("ar_mem_memwr", memWr, 0);
        chk("ar_mem_memreq", memReq, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_memwr", memWr, 1);
        chk("ar_memreq", memReq, 0);
        chk("ar_state", state, 0);
        chk("ar_busy", busy, 0);
        #3;
        rst = 1'b1;
        tick;
        chk("ar_idle", state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer for the processor core. It wraps the combinational instruction decoder and drives the single shared instruction/data memory port through a fetch/decode/execute/memory/writeback FSM. It gates the decoder's active-low register and memory write strobes so they assert only in the correct phase, and it produces the IR and PC load enables. It also counts retired instructions and flags a fault on a memory-handshake timeout.

## Interface
Parameters:
- CNT_W, 16, width of retired-instruction counter
- MEM_TIMEOUT, 15, consecutive un-acked request cycles tolerated before fault (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- run  in  1  1 = keep executing; sampled in IDLE and at end of WB
- operation  in  2  instruction class from decoder: 00 data-proc, 01 load/store, 10 branch, 11 reserved
- decRegWr  in  1  decoder register-write strobe, active-low
- decMemWr  in  1  decoder memory-write strobe, active-low
- decSelPC  in  1  decoder branch-taken
- memAck  in  1  memory completes current request this cycle
- memReq  out  1  memory request
- memAddrSel  out  1  0 = PC address, 1 = ALU result address
- memWr  out  1  gated memory write strobe, active-low
- irWr  out  1  load instruction register
- pcWr  out  1  load PC
- pcSrc  out  1  0 = PC+4, 1 = branch target
- regWr  out  1  gated register write strobe, active-low
- busy  out  1  1 in any state except IDLE and FAULT
- fault  out  1  memory timeout occurred; sticky until reset
- instrCount  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
- state  out  3  debug state code

## Operation
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7.
- Reset values (asynchronous):
  - state IDLE, memReq 0, memAddrSel 0, memWr 1, irWr 0, pcWr 0, pcSrc 0, regWr 1.
  - busy 0, fault 0, instrCount 0, wait counter 0.
- IDLE:
  - All strobes are inactive.
  - run=1 → FETCH.
- FETCH:
  - memReq=1, memAddrSel=0, memWr=1.
  - memAck=1 → irWr=1 in the same cycle, next state DECODE.
- DECODE: one cycle, no strobes. Decoder inputs must be valid from here through WB.
- EXEC:
  - One cycle, no strobes.
  - operation=01 → MEM; otherwise → WB.
- MEM:
  - memReq=1, memAddrSel=1, memWr=decMemWr.
  - memWr stays held until memAck; memAck=1 → WB.
- WB: one cycle.
  - pcWr=1, instrCount+1.
  - operation 00/01/10: regWr=decRegWr.
  - operation 11: regWr=1 (NOP).
  - pcSrc=decSelPC when operation=10, else 0.
  - Next state: run=1 → FETCH; run=0 → IDLE.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and counts cycles with memReq=1 and memAck=0.
  - If MEM_TIMEOUT such cycles accumulate, the FSM moves to FAULT on the next edge.
  - memAck on the cycle that would otherwise reach the limit is accepted normally.
- FAULT:
  - fault=1, all strobes inactive (memWr=1, regWr=1).
  - FAULT is exited only by rst.
- memAck outside FETCH/MEM is ignored.
- Deassertion of run takes effect only in IDLE or at WB. An instruction in flight always completes.
- instrCount wraps from 2^CNT_W−1 to 0 without a flag.

## Timing
- All outputs are Moore (registered state decode), except irWr, which is the combinational AND of FETCH and memAck.
- Zero-wait memory (memAck in first request cycle):
  - data-proc and branch: 4 cycles per instruction (FETCH, DECODE, EXEC, WB).
  - load/store: 5 cycles per instruction.
- Each cycle memAck is withheld adds one cycle.
- The first FETCH is one cycle after run is sampled high in IDLE.
- Back-to-back: with run=1, WB is followed directly by FETCH, with no idle bubble.
- rst asserted mid-operation forces reset values immediately, independent of clk. Any pending memory request is abandoned (memReq drops asynchronously).

## Test plan
- Reset/idle:
  - Stimulus: rst low, then high with run=0 for 10 cycles.
  - Required: state=0, memReq=0, memWr=1, regWr=1, busy=0, instrCount=0 throughout.
- Data-proc, zero-wait:
  - Stimulus: run=1, operation=00, decRegWr=0, memAck=1 always.
  - Required: states 1,2,3,5 repeating; regWr=0 only in WB; pcWr=1 only in WB; instrCount increments every 4 cycles.
- Store with 3 wait cycles in MEM:
  - Stimulus: operation=01, decMemWr=0.
  - Required: memAddrSel=1 and memWr=0 for exactly 4 MEM cycles; regWr stays 1 if decRegWr=1; instruction takes 8 cycles.
- Branch taken vs not taken:
  - Stimulus: operation=10 with decSelPC=1, then decSelPC=0.
  - Required: WB shows pcWr=1 with pcSrc=1, then pcSrc=0. Link case (decRegWr=0) gives regWr=0 in WB.
- Timeout, MEM_TIMEOUT=15:
  - Stimulus: memAck held 0 in FETCH.
  - Required: FAULT after 15 request cycles; fault=1 and busy=0 until rst.
  - Stimulus: ack arrives on the 15th cycle.
  - Required: no fault.
- Async reset in MEM with memWr=0, and counter wrap:
  - Stimulus: rst asserted while in MEM with memWr=0.
  - Required: memWr returns to 1 and memReq to 0 before the next edge.
  - Stimulus: CNT_W=4, 16 retired instructions.
  - Required: instrCount returns to 0.
